// File: rtl/key_bounce_gen.sv
// Mechanical-key waveform generator: press bounces, stable-low hold, release
// bounces, then a stable-high settle, all on an active-low key line.
module key_bounce_gen #(
    parameter int unsigned CLK_FREQ_MHZ  = 50,
    parameter int unsigned GLITCH_MAX_NS = 1000,
    parameter int unsigned BOUNCE_CNT_W  = 4,
    parameter int unsigned HOLD_W        = 16,
    parameter int unsigned LFSR_EN       = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    start_i,
    input  logic [BOUNCE_CNT_W-1:0] bounces_i,
    input  logic [HOLD_W-1:0]       hold_cycles_i,
    output logic                    key_o,
    output logic                    busy_o,
    output logic                    done_stb_o
);

    localparam int unsigned GMAX_RAW  = (CLK_FREQ_MHZ * GLITCH_MAX_NS + 999) / 1000;
    localparam int unsigned GMAX      = (GMAX_RAW < 1) ? 1 : GMAX_RAW;
    localparam int unsigned CNT_W     = $clog2(GMAX + 1);
    localparam int unsigned MASK_W    = $clog2(GMAX);
    localparam logic [16:0] LFSR_MASK = 17'((64'd1 << MASK_W) - 64'd1);
    localparam logic [CNT_W-1:0] GMAX_C    = CNT_W'(GMAX);
    localparam logic [CNT_W-1:0] GMAX_M1_C = CNT_W'(GMAX - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS_B = 3'd1,
        HOLD    = 3'd2,
        REL_B   = 3'd3,
        SETTLE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    key_q, key_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        w_q, w_d;
    logic                    half_q, half_d;
    logic [BOUNCE_CNT_W-1:0] bnc_q, bnc_d;
    logic [BOUNCE_CNT_W-1:0] bnc_cnt_q, bnc_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;

    logic [16:0]             w_raw;
    logic [CNT_W-1:0]        w_draw;
    logic [CNT_W-1:0]        w_draw_m1;
    logic [15:0]             lfsr_next;
    logic                    cnt_last;
    logic                    bnc_last;

    // Width of the next bounce and the LFSR step that goes with drawing it
    always_comb begin
        lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        w_raw     = ({1'b0, lfsr_q} & LFSR_MASK) + 17'd1;
        if (LFSR_EN != 0) begin
            w_draw = (w_raw > 17'(GMAX)) ? GMAX_C : CNT_W'(w_raw);
        end else begin
            w_draw = GMAX_C;
        end
        w_draw_m1 = w_draw - CNT_W'(1);
        cnt_last  = (cnt_q == '0);
        bnc_last  = (bnc_cnt_q == BOUNCE_CNT_W'(1));
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        done_d     = 1'b0;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        half_d     = half_q;
        bnc_d      = bnc_q;
        bnc_cnt_d  = bnc_cnt_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                key_d = 1'b1;
                if (start_i) begin
                    key_d     = 1'b0;
                    bnc_d     = bounces_i;
                    bnc_cnt_d = bounces_i;
                    // Hold counter is untouched during press bounces, so load it now
                    hold_cnt_d = (hold_cycles_i == '0) ? '0 : hold_cycles_i - HOLD_W'(1);
                    if (bounces_i == '0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = PRESS_B;
                        half_d  = 1'b0;
                        w_d     = w_draw;
                        cnt_d   = w_draw_m1;
                        lfsr_d  = lfsr_next;
                    end
                end
            end
            PRESS_B, REL_B: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!half_q) begin
                    half_d = 1'b1;
                    cnt_d  = w_q - CNT_W'(1);
                    key_d  = ~key_q;
                end else if (bnc_last) begin
                    half_d = 1'b0;
                    if (state_q == PRESS_B) begin
                        state_d = HOLD;
                        key_d   = 1'b0;
                    end else begin
                        state_d = SETTLE;
                        key_d   = 1'b1;
                        cnt_d   = GMAX_M1_C;
                    end
                end else begin
                    half_d    = 1'b0;
                    key_d     = ~key_q;
                    bnc_cnt_d = bnc_cnt_q - BOUNCE_CNT_W'(1);
                    w_d       = w_draw;
                    cnt_d     = w_draw_m1;
                    lfsr_d    = lfsr_next;
                end
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else if (bnc_q == '0) begin
                    state_d = SETTLE;
                    key_d   = 1'b1;
                    half_d  = 1'b0;
                    cnt_d   = GMAX_M1_C;
                end else begin
                    state_d   = REL_B;
                    key_d     = 1'b1;
                    half_d    = 1'b0;
                    bnc_cnt_d = bnc_q;
                    w_d       = w_draw;
                    cnt_d     = w_draw_m1;
                    lfsr_d    = lfsr_next;
                end
            end
            SETTLE: begin
                // Settle is 2*GMAX cycles, counted as two GMAX halves
                if (!cnt_last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!half_q) begin
                    half_d = 1'b1;
                    cnt_d  = GMAX_M1_C;
                end else begin
                    state_d = IDLE;
                    half_d  = 1'b0;
                    key_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                key_d   = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            key_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            w_q        <= '0;
            half_q     <= 1'b0;
            bnc_q      <= '0;
            bnc_cnt_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            half_q     <= half_d;
            bnc_q      <= bnc_d;
            bnc_cnt_q  <= bnc_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign key_o      = key_q;
    assign busy_o     = busy_q;
    assign done_stb_o = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: fixed-width and LFSR-width instances (GMAX=3),
// expected waveforms queued from a small model and compared cycle by cycle.
module tb_key_bounce_gen;

    localparam int unsigned GMAX = 3;

    typedef struct packed {
        logic key;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        int b;
        int h;
        int sel;
        int exp_done;
        bit mid_start;
    } vec_t;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [3:0]  bounces = '0;
    logic [15:0] hold = '0;
    logic        key_a, busy_a, done_a;
    logic        key_b, busy_b, done_b;
    logic        sel_cur = 1'b0;
    logic        key_s, busy_s, done_s;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    key_bounce_gen #(
        .CLK_FREQ_MHZ (3),
        .GLITCH_MAX_NS(1000),
        .BOUNCE_CNT_W (4),
        .HOLD_W       (16),
        .LFSR_EN      (0),
        .LFSR_SEED    (16'hACE1)
    ) dut_a (
        .clk_i        (clk),
        .srst_i       (srst),
        .start_i      (start_a),
        .bounces_i    (bounces),
        .hold_cycles_i(hold),
        .key_o        (key_a),
        .busy_o       (busy_a),
        .done_stb_o   (done_a)
    );

    key_bounce_gen #(
        .CLK_FREQ_MHZ (3),
        .GLITCH_MAX_NS(1000),
        .BOUNCE_CNT_W (4),
        .HOLD_W       (16),
        .LFSR_EN      (1),
        .LFSR_SEED    (16'hACE1)
    ) dut_b (
        .clk_i        (clk),
        .srst_i       (srst),
        .start_i      (start_b),
        .bounces_i    (bounces),
        .hold_cycles_i(hold),
        .key_o        (key_b),
        .busy_o       (busy_b),
        .done_stb_o   (done_b)
    );

    assign key_s  = sel_cur ? key_b  : key_a;
    assign busy_s = sel_cur ? busy_b : busy_a;
    assign done_s = sel_cur ? done_b : done_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic draw_w(input int sel, output int w);
        if (sel == 0) begin
            w = GMAX;
        end else begin
            w = 1 + int'(m_lfsr & 16'h0003);
            if (w > GMAX) w = GMAX;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    endtask

    task automatic push_n(input int n, input logic key);
        for (int i = 0; i < n; i++) exp_q.push_back('{key: key, busy: 1'b1, done: 1'b0});
    endtask

    // Expected {key,busy,done} per cycle from k+1 through the done cycle
    task automatic build(input int b, input int h, input int sel);
        int w;
        exp_q.delete();
        for (int i = 0; i < b; i++) begin
            draw_w(sel, w);
            push_n(w, 1'b0);
            push_n(w, 1'b1);
        end
        push_n((h < 1) ? 1 : h, 1'b0);
        for (int i = 0; i < b; i++) begin
            draw_w(sel, w);
            push_n(w, 1'b1);
            push_n(w, 1'b0);
        end
        push_n(2 * GMAX, 1'b1);
        exp_q.push_back('{key: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    // Entered and left at #1 after an edge; leaves during the done cycle
    task automatic run_seq(input int b, input int h, input int sel, input int exp_done,
                           input bit mid_start);
        exp_t e;
        int   n;
        int   done_at;
        int   want_done;
        build(b, h, sel);
        want_done = (exp_done < 0) ? exp_q.size() : exp_done;
        sel_cur = sel[0];
        bounces = 4'(b);
        hold    = 16'(h);
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        bounces = ~bounces;
        hold    = 16'($urandom);
        n = 1;
        done_at = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("wave b=%0d h=%0d n=%0d", b, h, n),
                  32'({key_s, busy_s, done_s}), 32'(e));
            if (done_s && done_at == 0) done_at = n;
            if (mid_start && n == 5) begin
                if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check($sformatf("done_cycle b=%0d h=%0d", b, h), 32'(done_at), 32'(want_done));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{b: 2,  h: 10, sel: 0, exp_done: 41,  mid_start: 1'b0};
        vecs[1] = '{b: 0,  h: 0,  sel: 0, exp_done: 8,   mid_start: 1'b0};
        vecs[2] = '{b: 0,  h: 1,  sel: 0, exp_done: 8,   mid_start: 1'b0};
        vecs[3] = '{b: 1,  h: 0,  sel: 0, exp_done: 20,  mid_start: 1'b1};
        vecs[4] = '{b: 3,  h: 5,  sel: 0, exp_done: 48,  mid_start: 1'b1};
        vecs[5] = '{b: 15, h: 2,  sel: 0, exp_done: 189, mid_start: 1'b0};
        vecs[6] = '{b: 15, h: 3,  sel: 1, exp_done: -1,  mid_start: 1'b1};
        vecs[7] = '{b: 4,  h: 0,  sel: 1, exp_done: -1,  mid_start: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'({key_a, busy_a, done_a}), 32'b100);
        check("reset_b", 32'({key_b, busy_b, done_b}), 32'b100);
        srst = 1'b0;
        m_lfsr = 16'hACE1;
        @(posedge clk); #1;
        check("idle_a", 32'({key_a, busy_a, done_a}), 32'b100);

        // Each sequence starts on the previous done cycle (back-to-back)
        for (int i = 0; i < 8; i++) begin
            run_seq(vecs[i].b, vecs[i].h, vecs[i].sel, vecs[i].exp_done, vecs[i].mid_start);
        end

        // Reset during HOLD aborts the sequence with no done strobe
        sel_cur = 1'b0;
        bounces = 4'd2;
        hold    = 16'd10;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_reset_hold", 32'({key_a, busy_a}), 32'b01);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        m_lfsr = 16'hACE1;
        check("mid_reset_a", 32'({key_a, busy_a, done_a}), 32'b100);
        check("mid_reset_b", 32'({key_b, busy_b, done_b}), 32'b100);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset_idle n=%0d", i), 32'({key_a, busy_a, done_a}), 32'b100);
        end

        run_seq(2, 10, 0, 41, 1'b0);
        run_seq(15, 3, 1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
- Synthesizable generator of mechanical-key waveforms: the source end of the key line consumed by the team's key debouncer.
- On a start strobe, drives an active-low key line in this order: press-edge bounce glitches, a stable-low hold, release-edge bounce glitches, then a stable-high settle time.
- Used in hardware-in-loop self-test and as a stimulus source in debouncer benches.
- Glitch widths come from a 16-bit LFSR, or are fixed for deterministic runs.

Parameters:
- CLK_FREQ_MHZ, 50, clock frequency in MHz.
- GLITCH_MAX_NS, 1000, maximum width of one bounce glitch half-period in ns.
- BOUNCE_CNT_W, 4, width of the per-edge bounce count input.
- HOLD_W, 16, width of the hold-time input (clock cycles).
- LFSR_EN, 1: 1 = pseudo-random glitch widths; 0 = every width equals GMAX.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- srst_i  input  1  synchronous reset, active-high.
- start_i  input  1  one-cycle request; sampled only in IDLE.
- bounces_i  input  BOUNCE_CNT_W  number of glitches per edge; captured with start_i.
- hold_cycles_i  input  HOLD_W  stable-low duration in cycles; captured with start_i; 0 is treated as 1.
- key_o  output  1  generated key line; 1 = released, 0 = pressed. Registered.
- busy_o  output  1  high in every state except IDLE. Registered.
- done_stb_o  output  1  one-cycle pulse when a sequence completes. Registered.

Behaviour:
- Derived constant: GMAX = ceil(CLK_FREQ_MHZ*GLITCH_MAX_NS/1000), computed in integer arithmetic and forced to at least 1. Counters are sized $clog2(GMAX+1); hold counter is HOLD_W bits.
- Glitch width w:
  - LFSR_EN=0: w = GMAX.
  - LFSR_EN=1: w = 1 + (lfsr & (2^$clog2(GMAX) - 1)), saturated to GMAX.
  - w is drawn once per bounce and used for both halves of that bounce.
  - LFSR: Fibonacci, taps 16,14,13,11. Advances one step per drawn width only.
- Reset: state=IDLE, key_o=1, busy_o=0, done_stb_o=0, lfsr=LFSR_SEED, all counters 0. A reset mid-sequence aborts it; key_o=1 on the cycle after srst_i is sampled, and no done_stb_o is issued.
- FSM states: IDLE, PRESS_B, HOLD, REL_B, SETTLE.
- IDLE: key_o=1. start_i=1 at edge k captures inputs; key_o=0 and busy_o=1 from k+1.
  - bounces_i=0: go to HOLD.
  - otherwise: go to PRESS_B.
- PRESS_B: each bounce is w cycles low, then w cycles high. After bounces_i bounces, go to HOLD.
- HOLD: key_o=0 for max(hold_cycles_i,1) cycles, then go to REL_B, or to SETTLE if bounces_i=0.
- REL_B: each bounce is w cycles high, then w cycles low. After bounces_i bounces, go to SETTLE.
- SETTLE: key_o=1 for 2*GMAX cycles. Then IDLE, with done_stb_o=1 and busy_o=0 on the first IDLE cycle.
- A start_i asserted on the done_stb_o cycle is accepted (back-to-back sequences).
- start_i outside IDLE is ignored, with no queuing. Captured inputs are not affected by changes to bounces_i or hold_cycles_i after capture.
- Total sequence length with fixed widths, from key_o falling to done_stb_o: 4*bounces*GMAX + max(hold,1) + 2*GMAX cycles.

Test Plan:
- Reset values: LFSR_EN=0, CLK_FREQ_MHZ=3, GLITCH_MAX_NS=1000 (GMAX=3); hold srst_i → key_o=1, busy_o=0, done_stb_o=0.
- Basic press (same parameters): start at edge k, bounces=2, hold=10 →
  - key_o pattern 000111000111 over k+1..k+12;
  - key_o low k+13..k+22;
  - key_o pattern 111000111000 over k+23..k+34;
  - key_o high k+35..k+40;
  - done_stb_o=1 at k+41 only.
- Degenerate inputs: bounces=0, hold=0 → key_o low exactly at k+1, high from k+2, done_stb_o at k+8.
- Busy and back-to-back: start_i pulsed mid-sequence → ignored, with an unchanged waveform. start_i on the done_stb_o cycle → key_o low on the next cycle.
- Reset mid-sequence: srst_i during HOLD → key_o=1 and busy_o=0 the next cycle; no done_stb_o. A new start then runs a full correct sequence, and with LFSR_EN=1 repeats the post-reset width sequence exactly.
- Debouncer loopback: key_o drives the debouncer; debouncer GLITCH_TIME_NS=500, generator GLITCH_MAX_NS=200, LFSR_EN=1, bounces=15, hold=1000 cycles → exactly one key_pressed_stb_o per sequence across 100 random sequences.
